// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared types and constants for the sequential restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

  localparam int c_DEFAULT_WIDTH = 16;
  localparam int c_CNT_W         = $clog2(c_DEFAULT_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step (shift in a bit, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_p,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_t;

  always_comb begin
    w_t     = {i_p, i_bit};
    o_q_bit = (w_t >= {1'b0, i_d});
    // For in-range operands P < D, so T - D < D always fits in WIDTH bits.
    o_p     = o_q_bit ? WIDTH'(w_t - {1'b0, i_d}) : w_t[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/divider_32by16_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_32by16_seq
// Brief    : Sequential unsigned restoring divider, 2W/W -> W quotient + W remainder,
//            one quotient bit per clock. Optional macro DIV_OVF_CHECK_EN enables err.
// Revision : 1.0 - initial release
// ============================================================================
module divider_32by16_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               err
);

  localparam int             c_CW   = $clog2(WIDTH) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  div_state_e        r_state;
  div_state_e        w_next_state;
  logic [WIDTH-1:0]  r_p;
  logic [WIDTH-1:0]  r_s;
  logic [WIDTH-1:0]  r_d;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_r;
  logic [WIDTH-1:0]  w_step_p;
  logic              w_step_q;
  logic              w_accept;
  logic              w_last;
  logic              w_ovf;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p     (r_p),
    .i_bit   (r_s[WIDTH-1]),
    .i_d     (r_d),
    .o_p     (w_step_p),
    .o_q_bit (w_step_q)
  );

`ifdef DIV_OVF_CHECK_EN
  logic r_err;
  assign w_ovf = (b == '0) || (a[2*WIDTH-1:WIDTH] >= b);
  assign err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_ovf) begin
      r_err <= 1'b1;
    end else if (r_state == RUN && w_last) begin
      r_err <= 1'b0;
    end
  end
`else
  assign w_ovf = 1'b0;
  assign err   = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == c_LAST);
  assign q        = r_q;
  assign r        = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_next_state = w_ovf ? DONE : RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: q/r are only written on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_s   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_p   <= a[2*WIDTH-1:WIDTH];
            r_s   <= a[WIDTH-1:0];
            r_d   <= b;
            r_cnt <= '0;
            if (w_ovf) begin
              r_q <= '1;
              r_r <= a[WIDTH-1:0];
            end
          end
        end
        RUN: begin
          r_p   <= w_step_p;
          r_s   <= {r_s[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt + c_CW'(1);
          if (w_last) begin
            r_q <= {r_s[WIDTH-2:0], w_step_q};
            r_r <= w_step_p;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_32by16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_32by16_seq
// Brief    : Directed self-checking bench for divider_32by16_seq; expectations
//            follow DIV_OVF_CHECK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_32by16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  divider_32by16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the one right after the accepting edge; returns when done is seen.
  task automatic wait_done(input int c0, output int cyc, output int nb);
    cyc = c0;
    nb  = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) nb++;
    end
  endtask

  task automatic accept(input logic [31:0] ta, input logic [15:0] tb_b);
    @(negedge clk);
    a = ta; b = tb_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_div(input logic [31:0] ta, input logic [15:0] tb_b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic eerr, input int elat, input string tag);
    int cyc, nb;
    accept(ta, tb_b);
    chk({tag, ".busy_on"}, busy, 1);
    wait_done(1, cyc, nb);
    chk({tag, ".latency"}, cyc, elat);
    chk({tag, ".busy_cycles"}, nb, elat);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".r"}, r, er);
    chk({tag, ".err"}, err, eerr);
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, done, 0);
    chk({tag, ".busy_drop"}, busy, 0);
  endtask

  initial begin
    int cyc, nb, cnt;
    logic [15:0] rb, rx, ry;
    logic [31:0] ra;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.q", q, 0);
    chk("reset.r", r, 0);
    chk("reset.err", err, 0);
    @(negedge clk); rst_n = 1'b1;

    run_div(32'h000F4240, 16'h03E8, 16'h03E8, 16'h0000, 1'b0, 17, "million");
    run_div(32'h12345678, 16'hFFFF, 16'h1234, 16'h68AC, 1'b0, 17, "maxdiv");
    run_div(32'h00000007, 16'h0003, 16'h0002, 16'h0001, 1'b0, 17, "small");

    // Back-to-back: start held from the done cycle is taken at the first idle edge.
    accept(32'h12345678, 16'hFFFF);
    wait_done(1, cyc, nb);
    chk("b2b.first_lat", cyc, 17);
    chk("b2b.first_q", q, 16'h1234);
    a = 32'h00000007; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b.ignored_in_done", busy, 0);
    chk("b2b.q_held", q, 16'h1234);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.second_accepted", busy, 1);
    wait_done(1, cyc, nb);
    chk("b2b.second_lat", cyc, 17);
    chk("b2b.second_q", q, 16'h0002);
    chk("b2b.second_r", r, 16'h0001);
    @(posedge clk); #1;

    // Start re-pulsed mid-operation with different operands must be ignored.
    accept(32'h000F4240, 16'h03E8);
    repeat (4) @(posedge clk);
    @(negedge clk); a = 32'h00000007; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(6, cyc, nb);
    chk("midstart.lat", cyc, 17);
    chk("midstart.q", q, 16'h03E8);
    chk("midstart.r", r, 16'h0000);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("midstart.extra_done", cnt, 0);

    // Asynchronous reset at RUN step 8 clears outputs without a clock edge.
    accept(32'h12345678, 16'hFFFF);
    repeat (8) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("areset.busy", busy, 0);
    chk("areset.done", done, 0);
    chk("areset.q", q, 0);
    chk("areset.r", r, 0);
    chk("areset.err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    run_div(32'h00000007, 16'h0003, 16'h0002, 16'h0001, 1'b0, 17, "after_reset");

`ifdef DIV_OVF_CHECK_EN
    run_div(32'h00001234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1, "ovf.div0");
    run_div(32'h00100000, 16'h0010, 16'hFFFF, 16'h0000, 1'b1, 1, "ovf.big");
    run_div(32'h00000007, 16'h0003, 16'h0002, 16'h0001, 1'b0, 17, "ovf.err_clear");
`else
    run_div(32'h00001234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 17, "div0");
`endif

    // Multiplier products divide back to the other factor exactly.
    run_div(32'hABCD * 32'h1234, 16'h1234, 16'hABCD, 16'h0000, 1'b0, 17, "prod.a");
    run_div(32'hFFFF * 32'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 17, "prod.max");
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom_range(1, 65535));
      run_div({16'h0, rx} * {16'h0, ry}, ry, rx, 16'h0000, 1'b0, 17, "prod.rand");
    end

    // Random in-range pairs (dividend high half below divisor).
    for (int i = 0; i < 200; i++) begin
      rb = 16'($urandom_range(1, 65535));
      ra = {16'($urandom_range(0, int'(rb) - 1)), 16'($urandom)};
      run_div(ra, rb, 16'(ra / {16'h0, rb}), 16'(ra % {16'h0, rb}), 1'b0, 17, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
